rx_sta_axil_regs: RTL
=====================

# rx_sta_axil_regs

AXI4-Lite slave register bank serving the S00_AXI/S01_AXI control ports of the RX STA block. It holds four 32-bit read/write configuration registers and exports them to the RX datapath, with a one-cycle write pulse per register. It is the responder end of the AXI4-Lite master VIP traffic used in block-level benches. Single outstanding write and single outstanding read, handled by independent channels.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; minimum 4.
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- cfg_reg0 .. cfg_reg3  out  32 each  current register contents.
- cfg_wr_pulse  out  4  bit n high for one cycle after regN is written.

## Operation
- Register select is addr[3:2]: 0x0→reg0, 0x4→reg1, 0x8→reg2, 0xC→reg3. addr[1:0] is ignored.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_AW: AW captured; awready=0, wready=1.
  - W_HAVE_W: W captured; awready=1, wready=0.
  - W_RESP: bvalid=1, both readies 0.
- Write FSM transitions:
  - Both handshakes in the same cycle in W_IDLE go straight to W_RESP.
  - The second handshake in W_HAVE_AW or W_HAVE_W goes to W_RESP.
  - In W_RESP, bvalid&bready returns to W_IDLE.
- Register update happens on the edge that completes the second handshake. Byte lane k is written only if wstrb[k]=1. The matching cfg_wr_pulse bit is high the following cycle, even if wstrb=0.
- Read FSM states: R_IDLE (arready=1) and R_DATA (rvalid=1, arready=0).
  - arvalid&arready registers rdata and rresp and moves to R_DATA.
  - rvalid&rready returns to R_IDLE.
- bresp and rresp are OKAY (2'b00) unless the Configuration macro is enabled.
- A read and a write in the same cycle to the same register: the read returns the pre-write value. The channels never stall each other.

## Timing
- Reset values:
  - all readies 0, bvalid 0, rvalid 0
  - bresp and rresp 2'b00, rdata 0
  - cfg_reg0..3 = 0, cfg_wr_pulse = 0
  - both FSMs in IDLE
- The readies are registered. They rise on the first ACLK edge after ARESETN deasserts.
- Write latency: bvalid is high the cycle after the last of AW/W handshakes. New register value is visible on cfg_regN in that same cycle.
- Read latency: rvalid is high the cycle after the AR handshake. rdata and rresp stay stable while rvalid=1 and rready=0.
- bvalid, bresp, rvalid and rdata are held until accepted. After a response is accepted, the readies reassert in the next cycle. Throughput is 1 transaction per 2 cycles per channel at best.
- ARESETN asserted mid-transaction aborts it immediately:
  - a pending response is dropped and no partial register write occurs
  - all outputs return to their reset values asynchronously

## Configuration
- RX_STA_AXIL_SLVERR_EN defined:
  - Any access with address bits above [3:2] nonzero gets SLVERR (2'b10).
  - On such a write, no register is written and cfg_wr_pulse stays 0.
  - On such a read, rdata=0.
- RX_STA_AXIL_SLVERR_EN undefined:
  - Upper address bits are ignored, so registers alias every 16 bytes.
  - Responses are always OKAY.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back → rdata 0x1..0x4 with OKAY, cfg_reg0..3 = 1..4, and cfg_wr_pulse bits 0..3 fire once each.
- W presented 3 cycles before AW (addr 0x8, data 0xDEADBEEF) → wready drops after the W handshake, bvalid follows the AW handshake by 1 cycle, cfg_reg2 = 0xDEADBEEF.
- reg1 = 0x11223344, then write 0xAABBCCDD with wstrb=0x3 → readback 0x1122CCDD.
- bready held low 5 cycles with a read issued meanwhile → bvalid and bresp stable for 5 cycles, and the read completes with 1-cycle latency regardless.
- ARESETN pulsed low while the write FSM is in W_HAVE_AW → no register change, all outputs 0, readies return 1 cycle after release.
- With RX_STA_AXIL_SLVERR_EN and C_S_AXI_ADDR_WIDTH=8, write to 0x14 → bresp 2'b10 and reg1 unchanged. Without the macro, the same write → OKAY and reg1 written.

Source files
------------

// File: rtl/rx_sta_axil_regs_if.sv
// AXI4-Lite bus bundle for the RX STA control register bank.
// The slave modport is used by rx_sta_axil_regs; master is for the driving side.
interface rx_sta_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr;
  logic [2:0]                        s_axi_awprot;
  logic                              s_axi_awvalid;
  logic                              s_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb;
  logic                              s_axi_wvalid;
  logic                              s_axi_wready;
  logic [1:0]                        s_axi_bresp;
  logic                              s_axi_bvalid;
  logic                              s_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr;
  logic [2:0]                        s_axi_arprot;
  logic                              s_axi_arvalid;
  logic                              s_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata;
  logic [1:0]                        s_axi_rresp;
  logic                              s_axi_rvalid;
  logic                              s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/rx_sta_axil_regs.sv
// AXI4-Lite slave holding four 32-bit config registers with a one-cycle write pulse each.
// Optional macro RX_STA_AXIL_SLVERR_EN: SLVERR for addresses with bits above [3:2] set.
module rx_sta_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  rx_sta_axil_regs_if.slave             s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg3,
  output logic [3:0]                    cfg_wr_pulse
);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic awready_reg, awready_next;
  logic wready_reg, wready_next;
  logic bvalid_reg, bvalid_next;
  logic [1:0] bresp_reg;
  logic arready_reg, arready_next;
  logic rvalid_reg, rvalid_next;
  logic [1:0] rresp_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [3:0] wr_pulse_reg;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_reg;
  logic [NB-1:0]                 w_strb_reg;

  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_mem_reg [4];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_commit, wr_err, wr_en, rd_err;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, wr_merged;
  logic [NB-1:0]                 wr_strb;
  logic [1:0] wr_sel, rd_sel;

  assign aw_hs = s_axi.s_axi_awvalid & awready_reg;
  assign w_hs  = s_axi.s_axi_wvalid & wready_reg;
  assign b_hs  = bvalid_reg & s_axi.s_axi_bready;
  assign ar_hs = s_axi.s_axi_arvalid & arready_reg;
  assign r_hs  = rvalid_reg & s_axi.s_axi_rready;

  // The second handshake may come from the bus or from the captured half.
  assign wr_addr = (w_state_reg == W_HAVE_AW) ? aw_addr_reg : s_axi.s_axi_awaddr;
  assign wr_data = (w_state_reg == W_HAVE_W) ? w_data_reg : s_axi.s_axi_wdata;
  assign wr_strb = (w_state_reg == W_HAVE_W) ? w_strb_reg : s_axi.s_axi_wstrb;
  assign wr_sel  = wr_addr[3:2];
  assign rd_sel  = s_axi.s_axi_araddr[3:2];

`ifdef RX_STA_AXIL_SLVERR_EN
  function automatic logic addr_high(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return (a >> 4) != '0;
  endfunction
  assign wr_err = addr_high(wr_addr);
  assign rd_err = addr_high(s_axi.s_axi_araddr);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_en = wr_commit & ~wr_err;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wr_merged[8*gi +: 8] = wr_strb[gi] ? wr_data[8*gi +: 8]
                                                : cfg_mem_reg[wr_sel][8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = w_state_reg;
    wr_commit    = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_next = W_RESP;
          wr_commit    = 1'b1;
        end else if (aw_hs) begin
          w_state_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        w_state_next = W_RESP;
        wr_commit    = 1'b1;
      end
      W_HAVE_W: if (aw_hs) begin
        w_state_next = W_RESP;
        wr_commit    = 1'b1;
      end
      W_RESP: if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    awready_next = (w_state_next == W_IDLE) || (w_state_next == W_HAVE_W);
    wready_next  = (w_state_next == W_IDLE) || (w_state_next == W_HAVE_AW);
    bvalid_next  = (w_state_next == W_RESP);
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (r_hs) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
    arready_next = (r_state_next == R_IDLE);
    rvalid_next  = (r_state_next == R_DATA);
  end

  // Readies come from registers so they stay low until the first edge after reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_reg  <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= 2'b00;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      wr_pulse_reg <= 4'b0000;
      for (int i = 0; i < 4; i++) cfg_mem_reg[i] <= '0;
    end else begin
      w_state_reg  <= w_state_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
      wr_pulse_reg <= wr_en ? (4'b0001 << wr_sel) : 4'b0000;
      if (aw_hs) aw_addr_reg <= s_axi.s_axi_awaddr;
      if (w_hs) begin
        w_data_reg <= s_axi.s_axi_wdata;
        w_strb_reg <= s_axi.s_axi_wstrb;
      end
      if (wr_commit) bresp_reg <= wr_err ? 2'b10 : 2'b00;
      if (wr_en) cfg_mem_reg[wr_sel] <= wr_merged;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= 2'b00;
      rdata_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      if (ar_hs) begin
        rdata_reg <= rd_err ? '0 : cfg_mem_reg[rd_sel];
        rresp_reg <= rd_err ? 2'b10 : 2'b00;
      end
    end
  end

  assign s_axi.s_axi_awready = awready_reg;
  assign s_axi.s_axi_wready  = wready_reg;
  assign s_axi.s_axi_bvalid  = bvalid_reg;
  assign s_axi.s_axi_bresp   = bresp_reg;
  assign s_axi.s_axi_arready = arready_reg;
  assign s_axi.s_axi_rvalid  = rvalid_reg;
  assign s_axi.s_axi_rresp   = rresp_reg;
  assign s_axi.s_axi_rdata   = rdata_reg;

  assign cfg_reg0     = cfg_mem_reg[0];
  assign cfg_reg1     = cfg_mem_reg[1];
  assign cfg_reg2     = cfg_mem_reg[2];
  assign cfg_reg3     = cfg_mem_reg[3];
  assign cfg_wr_pulse = wr_pulse_reg;

  logic unused_bits;
  assign unused_bits = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                         s_axi.s_axi_awaddr, s_axi.s_axi_araddr};
endmodule
